// File: rtl/dense_par.sv
`default_nettype none
// ============================================================================
// Module   : dense_par
// Brief    : Fully-connected layer computing PAR output neurons per pass over
//            the input vector; input reads are pipelined for any BRAM latency.
//            Define DENSE_RELU_EN to zero negative results after the clamp.
// Revision : 1.0 - initial release
// ============================================================================
module dense_par #(
    parameter int    DATA_WIDTH   = 16,
    parameter int    FRAC_BITS    = 7,
    parameter int    POST_SHIFT   = 2,
    parameter int    IN_DIM       = 1568,
    parameter int    OUT_DIM      = 10,
    parameter int    PAR          = 2,
    parameter int    LAT          = 2,
    parameter string WEIGHTS_FILE = "fc1_weights.mem",
    parameter string BIASES_FILE  = "fc1_biases.mem",
    localparam int   c_addr_w     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    output logic [c_addr_w-1:0]               in_addr,
    output logic                              in_en,
    input  logic [DATA_WIDTH-1:0]             in_q,
    output logic [OUT_DIM-1:0][DATA_WIDTH-1:0] out_vec,
    output logic                              busy,
    output logic                              done
);

    localparam int c_ng     = (OUT_DIM + PAR - 1) / PAR;
    localparam int c_grp_w  = (c_ng > 1) ? $clog2(c_ng) : 1;
    localparam int c_prod_w = 2 * DATA_WIDTH;
    localparam int c_acc_w  = 2 * DATA_WIDTH + c_addr_w + 2;
    localparam int c_rom_n  = OUT_DIM * IN_DIM;
    localparam int c_rom_w  = (c_rom_n > 1) ? $clog2(c_rom_n) : 1;
    localparam int c_bias_w = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int c_shift  = FRAC_BITS + POST_SHIFT;

    localparam logic [c_addr_w-1:0] c_idx_last   = c_addr_w'(IN_DIM - 1);
    localparam logic [c_grp_w-1:0]  c_grp_last   = c_grp_w'(c_ng - 1);
    localparam logic [3:0]          c_drain_last = 4'(LAT - 1);

    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min =
        {{(c_acc_w - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue  = 3'd1;
    localparam logic [2:0] c_st_drain  = 3'd2;
    localparam logic [2:0] c_st_write  = 3'd3;
    localparam logic [2:0] c_st_finish = 3'd4;

    logic signed [DATA_WIDTH-1:0] r_weight_rom [c_rom_n];
    logic signed [DATA_WIDTH-1:0] r_bias_rom   [OUT_DIM];

    logic [2:0]                 r_state;
    logic [c_grp_w-1:0]         r_grp;
    logic [c_addr_w-1:0]        r_idx;
    logic [3:0]                 r_cnt;
    logic                       r_in_en;
    logic                       r_busy;
    logic                       r_done;
    logic [LAT-1:0]             r_vpipe;
    logic [OUT_DIM-1:0][DATA_WIDTH-1:0] r_out_vec;

    logic                       w_preload;
    logic                       w_mac;
    logic [c_grp_w-1:0]         w_bias_grp;
    logic [PAR-1:0][DATA_WIDTH-1:0] w_result;

    assign in_addr = r_idx;
    assign in_en   = r_in_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign out_vec = r_out_vec;

    // Bias preload targets the group about to be issued, not the current one
    assign w_preload  = ((r_state == c_st_idle) && start) ||
                        ((r_state == c_st_write) && (r_grp != c_grp_last));
    assign w_bias_grp = (r_state == c_st_idle) ? '0 : (r_grp + c_grp_w'(1));
    assign w_mac      = r_vpipe[LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_grp   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_in_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= r_in_en;
            for (int k = 1; k < LAT; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_issue;
                        r_grp   <= '0;
                        r_idx   <= '0;
                        r_in_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_issue: begin
                    if (r_idx == c_idx_last) begin
                        r_state <= c_st_drain;
                        r_in_en <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_idx <= r_idx + c_addr_w'(1);
                    end
                end
                c_st_drain: begin
                    if (r_cnt == c_drain_last) begin
                        r_state <= c_st_write;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_st_write: begin
                    if (r_grp == c_grp_last) begin
                        r_state <= c_st_finish;
                        r_done  <= 1'b1;
                    end else begin
                        r_grp   <= r_grp + c_grp_w'(1);
                        r_state <= c_st_issue;
                        r_in_en <= 1'b1;
                    end
                end
                c_st_finish: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    for (genvar l = 0; l < PAR; l++) begin : g_lane
        logic [31:0]                  w_o;
        logic [31:0]                  w_bo;
        logic                         w_act;
        logic                         w_bact;
        logic [c_rom_w-1:0]           w_widx;
        logic [c_bias_w-1:0]          w_bidx;
        logic signed [c_prod_w-1:0]   w_prod;
        logic signed [c_acc_w-1:0]    w_bias_ext;
        logic signed [c_acc_w-1:0]    w_shifted;
        logic [DATA_WIDTH-1:0]        w_sat;
        logic signed [c_acc_w-1:0]    r_acc;
        logic signed [DATA_WIDTH-1:0] r_wpipe [LAT];

        // Lanes past OUT_DIM read index 0 so the ROM is never addressed out of range
        assign w_o    = 32'(r_grp) * 32'(PAR) + 32'(l);
        assign w_act  = w_o < 32'(OUT_DIM);
        assign w_widx = w_act ? c_rom_w'(w_o * 32'(IN_DIM) + 32'(r_idx)) : '0;
        assign w_bo   = 32'(w_bias_grp) * 32'(PAR) + 32'(l);
        assign w_bact = w_bo < 32'(OUT_DIM);
        assign w_bidx = w_bact ? c_bias_w'(w_bo) : '0;

        assign w_bias_ext = w_bact ? (c_acc_w'(r_bias_rom[w_bidx]) <<< FRAC_BITS) : '0;
        assign w_prod     = c_prod_w'($signed(in_q)) * c_prod_w'(r_wpipe[LAT-1]);
        assign w_shifted  = r_acc >>> c_shift;

        always_comb begin
            w_sat = w_shifted[DATA_WIDTH-1:0];
            if (w_shifted > c_sat_max) begin
                w_sat = c_sat_max[DATA_WIDTH-1:0];
            end else if (w_shifted < c_sat_min) begin
                w_sat = c_sat_min[DATA_WIDTH-1:0];
            end
`ifdef DENSE_RELU_EN
            if (w_sat[DATA_WIDTH-1]) begin
                w_sat = '0;
            end
`endif
        end

        assign w_result[l] = w_sat;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_acc <= '0;
                for (int k = 0; k < LAT; k++) begin
                    r_wpipe[k] <= '0;
                end
            end else begin
                r_wpipe[0] <= r_weight_rom[w_widx];
                for (int k = 1; k < LAT; k++) begin
                    r_wpipe[k] <= r_wpipe[k-1];
                end
                if (w_preload) begin
                    r_acc <= w_bias_ext;
                end else if (w_mac && w_act) begin
                    r_acc <= r_acc + c_acc_w'(w_prod);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vec <= '0;
        end else if (r_state == c_st_write) begin
            for (int o = 0; o < OUT_DIM; o++) begin
                if (32'(r_grp) == 32'(o / PAR)) begin
                    r_out_vec[o] <= w_result[o % PAR];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_par.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_par
// Brief    : Directed self-checking bench for dense_par (latency variants,
//            saturation, ReLU option, start protocol and asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_par;

    localparam int c_n   = 4;
    localparam int c_dim = 4;
    localparam int c_out = 5;

`ifdef DENSE_RELU_EN
    localparam int c_relu0 = 0;
`else
    localparam int c_relu0 = -10;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic                    start_v [c_n];
    logic                    en_v    [c_n];
    logic                    busy_v  [c_n];
    logic                    done_v  [c_n];
    logic [1:0]              addr_v  [c_n];
    logic [15:0]             q_v     [c_n];
    logic [c_out-1:0][15:0]  out_v   [c_n];
    logic [15:0]             x_mem   [c_dim];

    // Instances 0..3: LAT 2, 1, 5 and 2 (instance 3 carries the ReLU weights)
    for (genvar k = 0; k < c_n; k++) begin : g_std
        localparam int c_lat = (k == 1) ? 1 : ((k == 2) ? 5 : 2);
        logic [15:0] r_pipe [c_lat];
        always @(posedge clk) begin
            r_pipe[0] <= en_v[k] ? x_mem[addr_v[k]] : 16'hBEEF;
            for (int j = 1; j < c_lat; j++) r_pipe[j] <= r_pipe[j-1];
        end
        assign q_v[k] = r_pipe[c_lat-1];

        dense_par #(
            .DATA_WIDTH(16), .FRAC_BITS(0), .POST_SHIFT(0), .IN_DIM(c_dim),
            .OUT_DIM(c_out), .PAR(2), .LAT(c_lat), .WEIGHTS_FILE(""), .BIASES_FILE("")
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start_v[k]), .in_addr(addr_v[k]),
            .in_en(en_v[k]), .in_q(q_v[k]), .out_vec(out_v[k]), .busy(busy_v[k]),
            .done(done_v[k])
        );
    end

    logic            s_start, s_en, s_busy, s_done;
    logic [1:0]      s_addr;
    logic [7:0]      s_q;
    logic [1:0][7:0] s_out;
    logic [7:0]      s_pipe [2];
    logic [7:0]      s_x    [c_dim];

    always @(posedge clk) begin
        s_pipe[0] <= s_en ? s_x[s_addr] : 8'h55;
        s_pipe[1] <= s_pipe[0];
    end
    assign s_q = s_pipe[1];

    dense_par #(
        .DATA_WIDTH(8), .FRAC_BITS(0), .POST_SHIFT(0), .IN_DIM(c_dim),
        .OUT_DIM(2), .PAR(1), .LAT(2), .WEIGHTS_FILE(""), .BIASES_FILE("")
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .start(s_start), .in_addr(s_addr),
        .in_en(s_en), .in_q(s_q), .out_vec(s_out), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        int inst;
        int done_cyc;
        int exp [c_out];
    } vec_t;

    vec_t tbl [4];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input int k, input int exp [c_out], input string tag);
        for (int o = 0; o < c_out; o++) begin
            check($sformatf("%s inst%0d out_vec[%0d]", tag, k, o),
                  longint'($signed(out_v[k][o])), longint'(exp[o]));
        end
    endtask

    // One full run; busy, done and the in_en/in_addr schedule are checked every cycle
    task automatic run_std(input int k, input int exp_done, input bit repulse,
                           input int exp [c_out], input string tag);
        int done_at, done_cnt, busy_bad, en_bad, per, ph;
        done_at = -1; done_cnt = 0; busy_bad = 0; en_bad = 0;
        per = (exp_done - 1) / 3;
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
        for (int c = 1; c <= exp_done + 3; c++) begin
            ph = (c - 1) % per;
            if (busy_v[k] !== (c <= exp_done)) busy_bad++;
            if (done_v[k] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (c < exp_done && ph < c_dim) begin
                if (en_v[k] !== 1'b1 || addr_v[k] !== 2'(ph)) en_bad++;
            end else if (en_v[k] !== 1'b0) begin
                en_bad++;
            end
            start_v[k] = repulse && (c == 5);
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        check($sformatf("%s inst%0d done_cycle", tag, k), done_at, exp_done);
        check($sformatf("%s inst%0d done_count", tag, k), done_cnt, 1);
        check($sformatf("%s inst%0d busy_window_errors", tag, k), busy_bad, 0);
        check($sformatf("%s inst%0d in_en_schedule_errors", tag, k), en_bad, 0);
        check_out(k, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int basic [c_out];
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        s_start  = 1'b0;
        for (int k = 0; k < c_n; k++) start_v[k] = 1'b0;
        for (int i = 0; i < c_dim; i++) begin
            x_mem[i] = 16'(i + 1);
            s_x[i]   = 8'd127;
        end

        for (int o = 0; o < c_out; o++) begin
            for (int i = 0; i < c_dim; i++) begin
                g_std[0].u_dut.r_weight_rom[o*c_dim+i] = 16'(o + 1);
                g_std[1].u_dut.r_weight_rom[o*c_dim+i] = 16'(o + 1);
                g_std[2].u_dut.r_weight_rom[o*c_dim+i] = 16'(o + 1);
                g_std[3].u_dut.r_weight_rom[o*c_dim+i] = (o == 0) ? 16'd1 : 16'(o + 1);
            end
            g_std[0].u_dut.r_bias_rom[o] = 16'(o);
            g_std[1].u_dut.r_bias_rom[o] = 16'(o);
            g_std[2].u_dut.r_bias_rom[o] = 16'(o);
            g_std[3].u_dut.r_bias_rom[o] = (o == 0) ? 16'hFFEC : 16'(o);
        end
        for (int i = 0; i < c_dim; i++) begin
            u_sat.r_weight_rom[i]         = 8'h7F;
            u_sat.r_weight_rom[c_dim + i] = 8'h80;
        end
        u_sat.r_bias_rom[0] = 8'h00;
        u_sat.r_bias_rom[1] = 8'h00;

        basic  = '{10, 21, 32, 43, 54};
        tbl[0] = '{0, 22, '{10, 21, 32, 43, 54}};
        tbl[1] = '{1, 19, '{10, 21, 32, 43, 54}};
        tbl[2] = '{2, 31, '{10, 21, 32, 43, 54}};
        tbl[3] = '{3, 22, '{c_relu0, 21, 32, 43, 54}};

        repeat (3) @(negedge clk);
        check("reset busy", busy_v[0], 0);
        check("reset done", done_v[0], 0);
        check("reset in_en", en_v[0], 0);
        check("reset in_addr", addr_v[0], 0);
        check_out(0, '{0, 0, 0, 0, 0}, "reset");
        reset_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run_std(tbl[t].inst, tbl[t].done_cyc, 1'b0, tbl[t].exp, "table");
        end

        // Saturation in an 8-bit configuration
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        c = 1;
        while (s_done !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("sat done_cycle", c, 15);
        check("sat out_vec[0]", longint'($signed(s_out[0])), 127);
        check("sat out_vec[1]", longint'($signed(s_out[1])), -128);

        // Second start during a run is ignored; rerun gives identical results
        run_std(0, 22, 1'b1, basic, "restart_ignored");

        // start in FINISH ignored, held into the next IDLE cycle accepted
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        c = 1;
        while (done_v[0] !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("finish done_cycle", c, 22);
        start_v[0] = 1'b1;
        @(negedge clk);
        check("start_in_finish busy", busy_v[0], 0);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("start_after_finish busy", busy_v[0], 1);
        c = 1;
        while (done_v[0] !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("back_to_back done_cycle", c, 22);
        check_out(0, basic, "back_to_back");
        repeat (3) @(negedge clk);

        // Asynchronous reset in cycle 9, then a clean run with partial-update check
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_out(0, '{0, 0, 0, 0, 0}, "midrun_reset");
        check("midrun_reset busy", busy_v[0], 0);
        check("midrun_reset in_en", en_v[0], 0);
        @(negedge clk);
        check("reset_held in_en", en_v[0], 0);
        check("reset_held done", done_v[0], 0);
        reset_n = 1'b1;

        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("partial out_vec[0]", longint'($signed(out_v[0][0])), 10);
        check("partial out_vec[1]", longint'($signed(out_v[0][1])), 21);
        check("partial out_vec[2] held", longint'($signed(out_v[0][2])), 0);
        check("partial busy", busy_v[0], 1);
        c = 8;
        while (done_v[0] !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("after_reset done_cycle", c, 22);
        check_out(0, basic, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
